// File: rtl/aes_pkg.sv
// Shared AES-128 tables, byte-level helpers and FSM encoding for the iterative encryptor.
// Internal block layout: FIPS-197 byte i lives at bits [127-8*i -: 8], column c is word [127-32*c -: 32].
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NUM_ROUNDS = 10;

  // Forward S-box; entry 0 sits in the most significant byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants for rounds 1..10.
  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic bit rpc_legal(input int unsigned rpc);
    return (rpc == 1) || (rpc == 2) || (rpc == 5) || (rpc == 10);
  endfunction

  // Round constant lookup; counters outside 1..10 yield zero so idle cycles index nothing.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if ((r >= 4'd1) && (r <= 4'd10)) v = RCON[r];
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[w[8*i +: 8]];
    return r;
  endfunction

  // Row r of the state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // One step of the AES-128 key schedule: produces the next four round-key words.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Reverse byte order; its own inverse, so it serves both directions.
  function automatic logic [127:0] byte_swap(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[127-8*i -: 8];
    return r;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES-128 encryption round with its matching key-schedule step.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] next_key
);

  logic [127:0] shifted;
  logic [127:0] mixed;

  // SubBytes, ShiftRows, MixColumns (skipped on the final round), AddRoundKey.
  always_comb begin
    next_key   = key_step(key, rcon);
    shifted    = shift_rows(sub_bytes(state));
    mixed      = last ? shifted : mix_columns(shifted);
    next_state = mixed ^ next_key;
  end

endmodule

// File: rtl/aes_iter.sv
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE rounds per clock, key expanded on the fly,
// valid/ready handshakes on both sides. The key register advances with every round, so each
// job must bring its own key.
module aes_iter
  import aes_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter bit          BYTE_SWAP        = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] g_input,
  input  logic [127:0] e_input,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] o
);

  if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_bad_rpc
    $error("aes_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] RPC4 = 4'(ROUNDS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;
  logic [127:0] o_q, o_d;
  logic         out_valid_q, out_valid_d;
  logic         accept;
  logic [127:0] blk_last;
  logic [127:0] key_last;

  // Translate between the port byte order and the internal FIPS-197 order.
  function automatic logic [127:0] port_map(input logic [127:0] x);
    return BYTE_SWAP ? byte_swap(x) : x;
  endfunction

  genvar gi;
  for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
    logic [127:0] st_in, key_in, st_out, key_out;
    logic [3:0]   round_num;

    if (gi == 0) begin : g_first
      assign st_in  = blk_q;
      assign key_in = key_q;
    end else begin : g_next
      assign st_in  = g_round[gi-1].st_out;
      assign key_in = g_round[gi-1].key_out;
    end

    // Rounds are numbered 1..10; the counter holds how many are already done.
    assign round_num = cnt_q + 4'(gi + 1);

    aes_round u_round (
      .state      (st_in),
      .key        (key_in),
      .rcon       (rcon_of(round_num)),
      .last       (round_num == 4'(NUM_ROUNDS)),
      .next_state (st_out),
      .next_key   (key_out)
    );
  end

  assign blk_last = g_round[ROUNDS_PER_CYCLE-1].st_out;
  assign key_last = g_round[ROUNDS_PER_CYCLE-1].key_out;

  assign in_ready  = rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign o         = o_q;

  // Next-state logic: run rounds, publish the result, and capture new jobs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    key_d       = key_q;
    o_d         = o_q;
    out_valid_d = out_valid_q;

    case (state_q)
      RUN: begin
        blk_d = blk_last;
        key_d = key_last;
        cnt_d = cnt_q + RPC4;
        if (cnt_d == 4'(NUM_ROUNDS)) begin
          o_d         = port_map(blk_last);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // A job captured in DONE overrides the return to IDLE, so there is no input bubble.
    if (accept) begin
      blk_d   = port_map(e_input) ^ port_map(g_input);
      key_d   = port_map(g_input);
      cnt_d   = 4'd0;
      state_d = RUN;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      blk_q       <= '0;
      key_q       <= '0;
      o_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_iter.sv
// Directed bench for aes_iter: FIPS-197 vectors, every ROUNDS_PER_CYCLE with byte swap,
// back-to-back jobs, backpressure, mid-run reset and ignored input.
module tb_aes_iter;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K3 = 128'he4dc18adf3d05ec9e4dcc41acb990007;
  localparam logic [127:0] P3 = 128'h4072da1240f930f7d3c8cf8b9322042e;
  localparam logic [127:0] C3 = 128'hd225406f484809186cb5d86be4098445;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv0, ir0, ov0, or0;
  logic [127:0] g0, e0, o0;

  logic         iv_s, or_s;
  logic [127:0] g_s, e_s;
  logic         ir_s [4];
  logic         ov_s [4];
  logic [127:0] o_s  [4];

  int n_checks = 0;
  int n_pass   = 0;

  aes_iter #(.ROUNDS_PER_CYCLE(1), .BYTE_SWAP(1'b0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv0),
    .in_ready  (ir0),
    .g_input   (g0),
    .e_input   (e0),
    .out_valid (ov0),
    .out_ready (or0),
    .o         (o0)
  );

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_sw
    localparam int unsigned RPC = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 5 : 10;
    aes_iter #(.ROUNDS_PER_CYCLE(RPC), .BYTE_SWAP(1'b1)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv_s),
      .in_ready  (ir_s[gi]),
      .g_input   (g_s),
      .e_input   (e_s),
      .out_valid (ov_s[gi]),
      .out_ready (or_s),
      .o         (o_s[gi])
    );
  end

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
    return r;
  endfunction

  // Waits for out_valid of the main instance; lat counts edges after the accept edge, -1 on timeout.
  task automatic wait_ov0(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov0 === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Presents one job to the main instance and returns at the negedge after the accept edge.
  task automatic start_job0(input logic [127:0] k, input logic [127:0] p, input logic ready);
    @(negedge clk);
    g0 = k; e0 = p; iv0 = 1'b1; or0 = ready;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; iv0 = 1'b0; or0 = 1'b0; g0 = '0; e0 = '0;
    iv_s = 1'b0; or_s = 1'b0; g_s = '0; e_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ov0 !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov0); else n_pass++;
    n_checks++; if (o0 !== 128'h0) $display("FAIL reset_o: got %h expected 0", o0); else n_pass++;
    n_checks++; if (ir0 !== 1'b0) $display("FAIL reset_in_ready_low: got %b expected 0", ir0); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (ov_s[k] !== 1'b0) $display("FAIL reset_sw%0d_out_valid: got %b expected 0", k, ov_s[k]); else n_pass++;
      n_checks++; if (o_s[k] !== 128'h0) $display("FAIL reset_sw%0d_o: got %h expected 0", k, o_s[k]); else n_pass++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ir0 !== 1'b1) $display("FAIL reset_release_in_ready: got %b expected 1", ir0); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_fips_c1;
    int lat;
    start_job0(K1, P1, 1'b0);
    n_checks++; if (ir0 !== 1'b0) $display("FAIL c1_in_ready_run: got %b expected 0", ir0); else n_pass++;
    wait_ov0(20, lat);
    n_checks++; if (lat !== 10) $display("FAIL c1_latency: got %0d expected 10", lat); else n_pass++;
    n_checks++; if (o0 !== C1) $display("FAIL c1_o: got %h expected %h", o0, C1); else n_pass++;
    n_checks++; if (ir0 !== 1'b0) $display("FAIL c1_in_ready_done: got %b expected 0", ir0); else n_pass++;
    or0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or0 = 1'b0;
    n_checks++; if (ov0 !== 1'b0) $display("FAIL c1_consume_valid: got %b expected 0", ov0); else n_pass++;
    n_checks++; if (o0 !== C1) $display("FAIL c1_o_retained: got %h expected %h", o0, C1); else n_pass++;
    n_checks++; if (ir0 !== 1'b1) $display("FAIL c1_idle_in_ready: got %b expected 1", ir0); else n_pass++;
    $display("test_fips_c1 latency=%0d o=%h", lat, o0);
  endtask

  task automatic test_swap_rpc;
    int lat [4];
    logic [127:0] ob [4];
    int rpc [4];
    rpc[0] = 1; rpc[1] = 2; rpc[2] = 5; rpc[3] = 10;
    for (int k = 0; k < 4; k++) begin
      lat[k] = -1;
      ob[k]  = '0;
    end
    @(negedge clk);
    g_s = bswap(K3); e_s = bswap(P3); iv_s = 1'b1; or_s = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv_s = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if ((ov_s[k] === 1'b1) && (lat[k] < 0)) begin
          lat[k] = n;
          ob[k]  = o_s[k];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (lat[k] !== 10 / rpc[k]) $display("FAIL swap_rpc%0d_latency: got %0d expected %0d", rpc[k], lat[k], 10 / rpc[k]); else n_pass++;
      n_checks++; if (ob[k] !== bswap(C3)) $display("FAIL swap_rpc%0d_o: got %h expected %h", rpc[k], ob[k], bswap(C3)); else n_pass++;
      $display("test_swap_rpc rpc=%0d latency=%0d o=%h", rpc[k], lat[k], ob[k]);
    end
    or_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (ov_s[k] !== 1'b0) $display("FAIL swap_rpc%0d_consume: got %b expected 0", rpc[k], ov_s[k]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    g0 = K1; e0 = P1; iv0 = 1'b1; or0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    g0 = K2; e0 = P2;
    wait_ov0(20, lat);
    n_checks++; if (lat !== 10) $display("FAIL b2b_first_latency: got %0d expected 10", lat); else n_pass++;
    n_checks++; if (o0 !== C1) $display("FAIL b2b_first_o: got %h expected %h", o0, C1); else n_pass++;
    n_checks++; if (ir0 !== 1'b1) $display("FAIL b2b_in_ready_done: got %b expected 1", ir0); else n_pass++;
    $display("test_back_to_back job1 latency=%0d o=%h", lat, o0);
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    n_checks++; if (ov0 !== 1'b0) $display("FAIL b2b_valid_drop: got %b expected 0", ov0); else n_pass++;
    n_checks++; if (ir0 !== 1'b0) $display("FAIL b2b_second_running: got %b expected 0", ir0); else n_pass++;
    wait_ov0(20, lat);
    n_checks++; if (lat !== 10) $display("FAIL b2b_second_latency: got %0d expected 10", lat); else n_pass++;
    n_checks++; if (o0 !== C2) $display("FAIL b2b_second_o: got %h expected %h", o0, C2); else n_pass++;
    $display("test_back_to_back job2 latency=%0d o=%h", lat, o0);
    @(posedge clk);
    @(negedge clk);
    or0 = 1'b0;
    n_checks++; if (ov0 !== 1'b0) $display("FAIL b2b_idle_valid: got %b expected 0", ov0); else n_pass++;
    n_checks++; if (ir0 !== 1'b1) $display("FAIL b2b_idle_ready: got %b expected 1", ir0); else n_pass++;
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    start_job0(K2, P2, 1'b0);
    wait_ov0(20, lat);
    n_checks++; if (lat !== 10) $display("FAIL bp_latency: got %0d expected 10", lat); else n_pass++;
    n_checks++; if (o0 !== C2) $display("FAIL bp_o: got %h expected %h", o0, C2); else n_pass++;
    bad = 0;
    g0 = {$urandom, $urandom, $urandom, $urandom};
    e0 = {$urandom, $urandom, $urandom, $urandom};
    iv0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (ov0 !== 1'b1) $display("FAIL bp_valid_stall%0d: got %b expected 1", i, ov0); else n_pass++;
      n_checks++; if (o0 !== C2) $display("FAIL bp_o_stall%0d: got %h expected %h", i, o0, C2); else n_pass++;
      n_checks++; if (ir0 !== 1'b0) $display("FAIL bp_ready_stall%0d: got %b expected 0", i, ir0); else n_pass++;
      g0 = {$urandom, $urandom, $urandom, $urandom};
      e0 = {$urandom, $urandom, $urandom, $urandom};
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or0 = 1'b0;
    n_checks++; if (ov0 !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", ov0); else n_pass++;
    n_checks++; if (o0 !== C2) $display("FAIL bp_release_o: got %h expected %h", o0, C2); else n_pass++;
    n_checks++; if (ir0 !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", ir0); else n_pass++;
    $display("test_backpressure latency=%0d o=%h", lat, o0);
  endtask

  task automatic test_reset_mid;
    int lat;
    start_job0(K1, P1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ov0 !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", ov0); else n_pass++;
    n_checks++; if (o0 !== 128'h0) $display("FAIL rstmid_o: got %h expected 0", o0); else n_pass++;
    n_checks++; if (ir0 !== 1'b0) $display("FAIL rstmid_ready: got %b expected 0", ir0); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ir0 !== 1'b1) $display("FAIL rstmid_release_ready: got %b expected 1", ir0); else n_pass++;
    n_checks++; if (ov0 !== 1'b0) $display("FAIL rstmid_no_output: got %b expected 0", ov0); else n_pass++;
    start_job0(K1, P1, 1'b0);
    wait_ov0(20, lat);
    n_checks++; if (lat !== 10) $display("FAIL rstmid_fresh_latency: got %0d expected 10", lat); else n_pass++;
    n_checks++; if (o0 !== C1) $display("FAIL rstmid_fresh_o: got %h expected %h", o0, C1); else n_pass++;
    $display("test_reset_mid fresh latency=%0d o=%h", lat, o0);
    or0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or0 = 1'b0;
  endtask

  task automatic test_ignored_input;
    int lat;
    int seen;
    start_job0(K2, P2, 1'b0);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov0 === 1'b1) begin
        lat = n;
        break;
      end
      if (n >= 2 && n <= 5) begin
        g0 = {$urandom, $urandom, $urandom, $urandom};
        e0 = {$urandom, $urandom, $urandom, $urandom};
        iv0 = 1'b1;
      end else begin
        iv0 = 1'b0;
      end
    end
    iv0 = 1'b0;
    n_checks++; if (lat !== 10) $display("FAIL ign_latency: got %0d expected 10", lat); else n_pass++;
    n_checks++; if (o0 !== C2) $display("FAIL ign_o: got %h expected %h", o0, C2); else n_pass++;
    or0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or0 = 1'b0;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov0 !== 1'b0) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL ign_garbage_output: got %0d valid cycles expected 0", seen); else n_pass++;
    n_checks++; if (ir0 !== 1'b1) $display("FAIL ign_idle_ready: got %b expected 1", ir0); else n_pass++;
    $display("test_ignored_input latency=%0d o=%h", lat, o0);
  endtask

  initial begin
    test_reset;
    test_fips_c1;
    test_swap_rpc;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_ignored_input;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_iter.md
Name: aes_iter

Overview:
- Sequential, parametrised successor to the single-cycle combinational AES-128 encryptor.
- Performs AES-128 encryption iteratively, ROUNDS_PER_CYCLE rounds per clock, with on-the-fly key expansion and valid/ready handshakes on input and output.
- Sits between the garbler/evaluator input registers and the output collector.
- Trades latency for gate count, which cuts garbled-circuit cost per clock.

Parameters:
- ROUNDS_PER_CYCLE, 1, AES rounds evaluated per clock; legal values 1, 2, 5, 10; other values are an elaboration error.
- BYTE_SWAP, 1, 1 = byte 0 of the FIPS-197 block maps to bits [7:0] on g_input, e_input and o; 0 = byte 0 maps to bits [127:120].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  g_input/e_input are valid.
- in_ready  output  1  block can accept a new job.
- g_input  input  128  cipher key, garbler side.
- e_input  input  128  plaintext, evaluator side.
- out_valid  output  1  o holds a completed ciphertext.
- out_ready  input  1  consumer accepts o.
- o  output  128  ciphertext, registered.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; out_valid=0; o=0; round counter=0; internal state and key registers=0. in_ready=0 whenever rst==0.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) or (state==DONE and out_ready).
- Accept: in_valid && in_ready at an edge.
  - Capture state = e_input XOR g_input (initial AddRoundKey, after BYTE_SWAP mapping) and key = g_input.
  - Counter=0; go to RUN.
- RUN: each cycle applies ROUNDS_PER_CYCLE rounds.
  - Each round: SubBytes, ShiftRows, MixColumns (omitted in round 10), AddRoundKey with the next expanded key.
  - The round key for round r comes from the key register via one key-schedule step with rcon[r].
  - Counter advances by ROUNDS_PER_CYCLE. When it reaches 10: o <= result (mapped back per BYTE_SWAP), out_valid<=1, state=DONE.
- Latency: accept edge to out_valid high = 10/ROUNDS_PER_CYCLE cycles (10, 5, 2, 1).
- DONE: o and out_valid hold stable until out_ready==1 at an edge.
  - If out_ready and in_valid at the same edge: output is consumed and the new job is captured; out_valid drops to 0 next cycle; state=RUN. No bubble on input.
  - If out_ready without in_valid: state=IDLE, out_valid=0; o retains its last value.
- in_valid is ignored in RUN and while in_ready==0; g_input/e_input are not sampled.
- out_ready is ignored outside DONE.
- Reset mid-operation (RUN or DONE): the job is discarded with no output; all reset values apply on the next cycle.
- Key register is updated every round, so the key must be re-supplied with every job. There is no key caching.

Decomposition:
- Package aes_pkg holds:
  - S-box as a constant array plus sub_bytes function.
  - xtime/gmul2 function.
  - rcon constant array [1..10].
  - byte-order swap function.
  - State enum {IDLE, RUN, DONE}.
  - ROUNDS_PER_CYCLE legality check.
- Sub-module aes_round (combinational): inputs state 128, key 128, rcon 8, last 1. Outputs next state 128 and next key 128.
- aes_iter instantiates ROUNDS_PER_CYCLE copies of aes_round in a generate chain and adds the FSM, counter and registers.

Test Plan:
- FIPS-197 C.1 vector, BYTE_SWAP=0, RPC=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> o=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 cycles after the accept edge.
- BYTE_SWAP=1, each RPC in {1,2,5,10}: g_input=swap(e4dc18adf3d05ec9e4dcc41acb990007), e_input=swap(4072da1240f930f7d3c8cf8b9322042e) -> o=swap(d225406f484809186cb5d86be4098445); latency 10/5/2/1.
- Back-to-back jobs: hold out_ready=1, in_valid=1 with two different vectors -> second job accepted on the same edge the first output is consumed; both ciphertexts correct; in_ready never low in DONE while out_ready=1.
- Backpressure: out_ready=0 for 20 cycles after completion -> o and out_valid stable; in_ready=0; a vector changed on g_input/e_input during the stall does not affect o.
- Reset: drive rst=0 for one cycle at cycle 4 of RUN -> next cycle out_valid=0, o=0, in_ready=0; after release in_ready=1 and a fresh job completes correctly.
- Ignored input: assert in_valid with garbage during RUN -> current result unchanged; garbage job never produces an output.
